// File: rtl/stepper_dec.sv
// Instruction step sequencer: keeps a binary step index plus its registered
// one-hot decode, flags wraps and illegal load targets with one-cycle pulses,
// and counts completed sequences with a saturating counter.
module stepper_dec #(
  parameter int STEPS = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_step,
  output logic [CNT_W-1:0] step_bin,
  output logic [STEPS-1:0] step_oh,
  output logic             wrap,
  output logic             load_err,
  output logic [7:0]       seq_cnt
);

  // STEPS widened by one bit so every load_step value compares without overflow
  localparam logic [CNT_W:0]   STEPS_EXT = (CNT_W+1)'(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [7:0]       CNT_MAX   = 8'hFF;

  logic [CNT_W-1:0] step_bin_reg, step_bin_next;
  logic [STEPS-1:0] step_oh_reg, step_oh_next;
  logic             wrap_reg, wrap_next;
  logic             load_err_reg, load_err_next;
  logic [7:0]       seq_cnt_reg, seq_cnt_next;
  logic             seq_done;
  logic             load_ok;

  assign load_ok = ({1'b0, load_step} < STEPS_EXT);

  // Next-state selection, priority clr > load > en > hold
  always_comb begin
    step_bin_next = step_bin_reg;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    seq_done      = 1'b0;
    if (clr) begin
      // An early restart only completes a sequence if we had left step 0
      step_bin_next = '0;
      seq_done      = (step_bin_reg != '0);
    end else if (load) begin
      // An out-of-range load freezes the state for this cycle, en included
      if (load_ok) begin
        step_bin_next = load_step;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (en) begin
      if (step_bin_reg == LAST_STEP) begin
        step_bin_next = '0;
        wrap_next     = 1'b1;
        seq_done      = 1'b1;
      end else begin
        step_bin_next = step_bin_reg + 1'b1;
      end
    end
  end

  // Saturating sequence counter update
  always_comb begin
    seq_cnt_next = seq_cnt_reg;
    if (seq_done && (seq_cnt_reg != CNT_MAX)) begin
      seq_cnt_next = seq_cnt_reg + 8'd1;
    end
  end

  // One-hot is decoded from the next binary index, so both registers agree every cycle
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_decode
    assign step_oh_next[gi] = (step_bin_next == CNT_W'(gi));
  end

  // State register with synchronous reset to step 0
  always_ff @(posedge clk) begin
    if (reset) begin
      step_bin_reg <= '0;
      step_oh_reg  <= STEPS'(1);
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
      seq_cnt_reg  <= '0;
    end else begin
      step_bin_reg <= step_bin_next;
      step_oh_reg  <= step_oh_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
      seq_cnt_reg  <= seq_cnt_next;
    end
  end

  assign step_bin = step_bin_reg;
  assign step_oh  = step_oh_reg;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;
  assign seq_cnt  = seq_cnt_reg;

endmodule

// File: tb/tb_stepper_dec.sv
// Scoreboard bench: four sequencers (STEPS 6, 2, 8, 16) share one control
// stream; a behavioural model predicts every output each cycle.
module tb_stepper_dec;

  logic       clk = 1'b0;
  logic       drv_reset = 1'b0, drv_en = 1'b0, drv_clr = 1'b0, drv_load = 1'b0;
  logic [3:0] drv_ls = 4'd0;

  logic [2:0]  bin6;  logic [5:0]  oh6;
  logic [0:0]  bin2;  logic [1:0]  oh2;
  logic [2:0]  bin8;  logic [7:0]  oh8;
  logic [3:0]  bin16; logic [15:0] oh16;
  logic [3:0]  wrap_v, err_v;
  logic [7:0]  cnt_v [4];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int inst;
    int bin;
    int oh;
    int wrap;
    int err;
    int cnt;
  } exp_t;

  exp_t sb_q[$];

  const int steps_t [4] = '{6, 2, 8, 16};
  const int cw_t    [4] = '{3, 1, 3, 4};
  int m_bin [4];
  int m_cnt [4];

  always #5 clk = ~clk;

  stepper_dec #(.STEPS(6), .CNT_W(3)) u_dut6 (
    .clk(clk), .reset(drv_reset), .en(drv_en), .clr(drv_clr), .load(drv_load),
    .load_step(drv_ls[2:0]), .step_bin(bin6), .step_oh(oh6),
    .wrap(wrap_v[0]), .load_err(err_v[0]), .seq_cnt(cnt_v[0]));

  stepper_dec #(.STEPS(2), .CNT_W(1)) u_dut2 (
    .clk(clk), .reset(drv_reset), .en(drv_en), .clr(drv_clr), .load(drv_load),
    .load_step(drv_ls[0:0]), .step_bin(bin2), .step_oh(oh2),
    .wrap(wrap_v[1]), .load_err(err_v[1]), .seq_cnt(cnt_v[1]));

  stepper_dec #(.STEPS(8), .CNT_W(3)) u_dut8 (
    .clk(clk), .reset(drv_reset), .en(drv_en), .clr(drv_clr), .load(drv_load),
    .load_step(drv_ls[2:0]), .step_bin(bin8), .step_oh(oh8),
    .wrap(wrap_v[2]), .load_err(err_v[2]), .seq_cnt(cnt_v[2]));

  stepper_dec #(.STEPS(16), .CNT_W(4)) u_dut16 (
    .clk(clk), .reset(drv_reset), .en(drv_en), .clr(drv_clr), .load(drv_load),
    .load_step(drv_ls[3:0]), .step_bin(bin16), .step_oh(oh16),
    .wrap(wrap_v[3]), .load_err(err_v[3]), .seq_cnt(cnt_v[3]));

  // Single comparison point: counts and reports
  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int obs_bin(input int i);
    case (i)
      0:       return int'(bin6);
      1:       return int'(bin2);
      2:       return int'(bin8);
      default: return int'(bin16);
    endcase
  endfunction

  function automatic int obs_oh(input int i);
    case (i)
      0:       return int'(oh6);
      1:       return int'(oh2);
      2:       return int'(oh8);
      default: return int'(oh16);
    endcase
  endfunction

  // Behavioural reference: reset > clr > load > en > hold
  task automatic model_next(input int i, input bit r, input bit c, input bit l,
                            input bit e, input int ls, output exp_t x);
    int steps, lsv;
    x.inst = i; x.wrap = 0; x.err = 0;
    steps = steps_t[i];
    lsv   = ls % (1 << cw_t[i]);
    if (r) begin
      m_bin[i] = 0;
      m_cnt[i] = 0;
    end else if (c) begin
      if (m_bin[i] != 0 && m_cnt[i] < 255) m_cnt[i]++;
      m_bin[i] = 0;
    end else if (l) begin
      if (lsv < steps) m_bin[i] = lsv;
      else x.err = 1;
    end else if (e) begin
      if (m_bin[i] == steps - 1) begin
        m_bin[i] = 0;
        x.wrap   = 1;
        if (m_cnt[i] < 255) m_cnt[i]++;
      end else begin
        m_bin[i]++;
      end
    end
    x.bin = m_bin[i];
    x.oh  = 1 << m_bin[i];
    x.cnt = m_cnt[i];
  endtask

  // One clock: drive, push predictions, clock, pop and compare
  task automatic cycle(input bit r, input bit c, input bit l, input bit e, input int ls);
    exp_t x;
    drv_reset = r; drv_clr = c; drv_load = l; drv_en = e; drv_ls = 4'(ls);
    for (int i = 0; i < 4; i++) begin
      model_next(i, r, c, l, e, ls, x);
      sb_q.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check_val($sformatf("s%0d_bin", steps_t[x.inst]), obs_bin(x.inst), x.bin);
      check_val($sformatf("s%0d_oh", steps_t[x.inst]), obs_oh(x.inst), x.oh);
      check_val($sformatf("s%0d_wrap", steps_t[x.inst]), int'(wrap_v[x.inst]), x.wrap);
      check_val($sformatf("s%0d_lerr", steps_t[x.inst]), int'(err_v[x.inst]), x.err);
      check_val($sformatf("s%0d_cnt", steps_t[x.inst]), int'(cnt_v[x.inst]), x.cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_bin[i] = 0; m_cnt[i] = 0; end
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    check_val("rst_bin", int'(bin6), 0);
    check_val("rst_oh", int'(oh6), 1);
    check_val("rst_cnt", int'(cnt_v[0]), 0);
    $display("txn reset done: bin=%0d oh=%b cnt=%0d", bin6, oh6, cnt_v[0]);

    // Thirteen enables: walk the ring twice plus one
    for (int k = 1; k <= 13; k++) begin
      cycle(0, 0, 0, 1, 0);
      check_val("run_oh", int'(oh6), 1 << (k % 6));
      check_val("run_wrap", int'(wrap_v[0]), (k == 6 || k == 12) ? 1 : 0);
      $display("txn en %0d: bin=%0d oh=%b wrap=%0d cnt=%0d", k, bin6, oh6, wrap_v[0], cnt_v[0]);
    end
    check_val("run_bin_end", int'(bin6), 1);
    check_val("run_cnt_end", int'(cnt_v[0]), 2);

    // Early restart from step 3 with en, then clr at step 0
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check_val("pre_clr_bin", int'(bin6), 3);
    cycle(0, 1, 0, 1, 0);
    check_val("clr_bin", int'(bin6), 0);
    check_val("clr_oh", int'(oh6), 1);
    check_val("clr_cnt", int'(cnt_v[0]), 3);
    check_val("clr_wrap", int'(wrap_v[0]), 0);
    $display("txn clr+en at 3: bin=%0d cnt=%0d", bin6, cnt_v[0]);
    cycle(0, 1, 0, 0, 0);
    check_val("clr0_cnt", int'(cnt_v[0]), 3);
    $display("txn clr at 0: cnt=%0d", cnt_v[0]);

    // Legal and illegal loads
    cycle(0, 0, 1, 0, 4);
    check_val("load4_oh", int'(oh6), 16);
    $display("txn load 4: oh=%b", oh6);
    cycle(0, 0, 1, 1, 6);
    check_val("load6_bin", int'(bin6), 4);
    check_val("load6_err", int'(err_v[0]), 1);
    $display("txn load 6+en: bin=%0d load_err=%0d", bin6, err_v[0]);
    cycle(0, 0, 0, 0, 0);
    check_val("load6_err_clr", int'(err_v[0]), 0);
    check_val("idle_bin", int'(bin6), 4);

    // Counter saturation: 300 wraps of the six-step ring
    for (int k = 0; k < 1800; k++) cycle(0, 0, 0, 1, 0);
    check_val("sat_cnt", int'(cnt_v[0]), 255);
    check_val("sat_bin", int'(bin6), 4);
    $display("txn 1800 en: cnt=%0d bin=%0d", cnt_v[0], bin6);
    cycle(1, 0, 0, 1, 0);
    check_val("midrst_bin", int'(bin6), 0);
    check_val("midrst_cnt", int'(cnt_v[0]), 0);
    $display("txn reset at step 4: bin=%0d cnt=%0d", bin6, cnt_v[0]);

    // Random traffic across all parameterisations
    for (int k = 0; k < 2000; k++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0),
            ($urandom_range(5) == 0), ($urandom_range(2) != 0),
            int'($urandom_range(15)));
    end
    $display("txn random traffic done: bins=%0d/%0d/%0d/%0d", bin6, bin2, bin8, bin16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_dec.md
STEPPER_DEC -- requirements
Module: stepper_dec

Interface
REQ-001 Parameter STEPS, default 6, number of steps in the sequence; legal range 2..16.
REQ-002 Parameter CNT_W, default 3, width of the binary step index; SHALL satisfy 2**CNT_W >= STEPS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  advance one step this cycle.
REQ-006 clr  input  1  early restart: return to step 0 (instruction finished early).
REQ-007 load  input  1  jump to step given by load_step.
REQ-008 load_step  input  CNT_W  binary target step for load.
REQ-009 step_bin  output  CNT_W  registered binary index of current step.
REQ-010 step_oh  output  STEPS  registered one-hot decode of step_bin; bit k high in step k.
REQ-011 wrap  output  1  one-cycle pulse; the sequence wrapped from STEPS-1 to 0 on the previous edge.
REQ-012 load_err  output  1  one-cycle pulse; the previous edge saw load with load_step >= STEPS.
REQ-013 seq_cnt  output  8  number of completed sequences (wraps plus clr restarts), saturating.

Function
REQ-014 step_oh SHALL always equal the one-hot decode of step_bin: exactly one bit set, never zero, never multi-hot, including the cycle after reset.
REQ-015 Priority per edge SHALL be reset > clr > load > en > hold.
REQ-016 en with step_bin < STEPS-1: step_bin increments by 1 and step_oh shifts left by 1 on the same edge.
REQ-017 en with step_bin == STEPS-1: step_bin becomes 0, step_oh becomes 1, wrap pulses high next cycle, and seq_cnt increments.
REQ-018 clr: step_bin becomes 0 and step_oh becomes 1; seq_cnt increments only if step_bin was nonzero; wrap stays 0.
REQ-019 load with load_step < STEPS: step_bin becomes load_step and step_oh sets bit load_step only; no wrap; seq_cnt unchanged.
REQ-020 load with load_step >= STEPS: state unchanged, load_err pulses high for one cycle, and en in the same cycle is ignored.
REQ-021 No control asserted: step_bin, step_oh and seq_cnt hold; wrap and load_err are 0.
REQ-022 wrap and load_err SHALL be registered pulses, high for exactly one cycle per event; back-to-back events give back-to-back pulses.
REQ-023 seq_cnt SHALL saturate at 255 and never roll over.
REQ-024 Latency: every control input affects outputs on the first rising edge after it is sampled; there is no combinational path from inputs to outputs.
REQ-025 clr together with load or en in the same cycle: clr wins; load_step is not checked and load_err stays 0.

Reset
REQ-026 On a reset edge: step_bin = 0, step_oh = 1 (bit 0), wrap = 0, load_err = 0, seq_cnt = 0.
REQ-027 Reset SHALL override all other inputs in the same cycle, including mid-sequence.
REQ-028 The first edge after reset deasserts SHALL respond normally to en/clr/load.

Verification
REQ-029 STEPS=6: reset, then en held for 13 cycles -> step_oh runs 000001..100000, wrap pulses after cycles 6 and 12, seq_cnt = 2, step_bin = 1.
REQ-030 At step 3, clr and en together -> step_bin = 0, step_oh = 000001, seq_cnt +1, wrap = 0; clr at step 0 -> seq_cnt unchanged.
REQ-031 load with load_step = 4 -> step_oh = 010000; load with load_step = 6 and en -> state held, load_err = 1 for one cycle only.
REQ-032 Force 300 wraps -> seq_cnt = 255 and holds; reset asserted at step 4 with en -> step_bin = 0 and seq_cnt = 0 next cycle.
REQ-033 Parameter sweep STEPS = 2, 8, 16 (CNT_W = 1, 3, 4): random en/clr/load traffic, checked every cycle -> step_oh one-hot and equal to the decode of step_bin, wrap only on the STEPS-1 to 0 transition.
